// File: rtl/pc_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pc_unit
// Program counter for the multicycle RISC-V core. Holds the architectural PC,
// captures the PC of the instruction in flight, and computes the next PC for
// sequential, PC-relative (branch/JAL), register-relative (JALR), trap-entry
// and MRET flows. A misaligned control-transfer target blocks the PC update,
// raises a one-cycle fault pulse and records the offending address.
//
// Parameters:
//   XLEN      datapath / PC width (32 or 64)
//   RESET_VEC PC after reset (must be IALIGN-aligned)
//   IALIGN    32 = base ISA alignment, 16 = compressed instructions allowed
//   STEP      byte increment for sequential fetch
//
// Ports:
//   clk            core clock, rising edge
//   rst            synchronous active-high reset
//   pc_we          commit the selected next-PC this cycle
//   pc_sel         0 SEQ, 1 REL, 2 ABS, 3 TRAP, 4 MRET, 5-7 reserved (no-op)
//   ir_latch       capture current pc into pc_old
//   imm            sign-extended immediate
//   rs1            JALR base register
//   mtvec          trap vector; [1:0] = mode (1 vectored, else direct)
//   mepc           exception return address
//   trap_cause     cause code used for vectored entry
//   trap_irq       trap is an interrupt
//   pc             architectural PC (registered)
//   pc_old         PC of the instruction being executed (registered)
//   pc_plus        pc_old + STEP (combinational, link value)
//   misalign_fault one-cycle pulse on a blocked misaligned transfer
//   fault_addr     last misaligned target (registered)
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     IALIGN    = 32,
  parameter int unsigned     STEP      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_we,
  input  logic [2:0]      pc_sel,
  input  logic            ir_latch,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [4:0]      trap_cause,
  input  logic            trap_irq,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_old,
  output logic [XLEN-1:0] pc_plus,
  output logic            misalign_fault,
  output logic [XLEN-1:0] fault_addr
);

  localparam logic [2:0] SEL_SEQ  = 3'd0;
  localparam logic [2:0] SEL_REL  = 3'd1;
  localparam logic [2:0] SEL_ABS  = 3'd2;
  localparam logic [2:0] SEL_TRAP = 3'd3;
  localparam logic [2:0] SEL_MRET = 3'd4;

  localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

  // Misalignment relative to the configured instruction alignment.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    logic mis;
    if (IALIGN == 16) begin
      mis = addr[0];
    end else begin
      mis = |addr[1:0];
    end
    return mis;
  endfunction

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_old_r;
  logic            fault_r;
  logic [XLEN-1:0] fault_addr_r;

  logic [XLEN-1:0] seq_tgt_s;
  logic [XLEN-1:0] rel_tgt_s;
  logic [XLEN-1:0] abs_sum_s;
  logic [XLEN-1:0] abs_tgt_s;
  logic [XLEN-1:0] trap_base_s;
  logic [XLEN-1:0] trap_off_s;
  logic            trap_vec_s;
  logic [XLEN-1:0] trap_tgt_s;
  logic [XLEN-1:0] mret_tgt_s;

  logic [XLEN-1:0] tgt_s;
  logic            chk_s;
  logic            valid_s;
  logic            mis_s;
  logic [XLEN-1:0] pc_nxt_s;
  logic            fault_nxt_s;
  logic [XLEN-1:0] fault_addr_nxt_s;

  // Candidate targets; all adds wrap modulo 2^XLEN.
  assign seq_tgt_s   = pc_r + STEP_W;
  assign rel_tgt_s   = pc_old_r + imm;
  assign abs_sum_s   = rs1 + imm;
  assign abs_tgt_s   = {abs_sum_s[XLEN-1:1], 1'b0};
  assign trap_base_s = {mtvec[XLEN-1:2], 2'b00};
  assign trap_off_s  = {{(XLEN-7){1'b0}}, trap_cause, 2'b00};
  // Only mode 1 with an interrupt vectors; modes 2/3 behave as direct.
  assign trap_vec_s  = (mtvec[1:0] == 2'b01) && trap_irq;
  assign trap_tgt_s  = trap_vec_s ? (trap_base_s + trap_off_s) : trap_base_s;
  assign mret_tgt_s  = {mepc[XLEN-1:1], 1'b0};

  // Select the target and whether it is subject to the alignment check.
  always_comb begin
    tgt_s   = pc_r;
    chk_s   = 1'b0;
    valid_s = 1'b0;
    case (pc_sel)
      SEL_SEQ:  begin tgt_s = seq_tgt_s;  chk_s = 1'b0; valid_s = 1'b1; end
      SEL_REL:  begin tgt_s = rel_tgt_s;  chk_s = 1'b1; valid_s = 1'b1; end
      SEL_ABS:  begin tgt_s = abs_tgt_s;  chk_s = 1'b1; valid_s = 1'b1; end
      SEL_TRAP: begin tgt_s = trap_tgt_s; chk_s = 1'b0; valid_s = 1'b1; end
      SEL_MRET: begin tgt_s = mret_tgt_s; chk_s = 1'b1; valid_s = 1'b1; end
      default:  begin tgt_s = pc_r;       chk_s = 1'b0; valid_s = 1'b0; end
    endcase
  end

  assign mis_s = chk_s && is_misaligned(tgt_s);

  // Next-state for pc and the fault outputs; the fault pulse clears by default.
  always_comb begin
    pc_nxt_s         = pc_r;
    fault_nxt_s      = 1'b0;
    fault_addr_nxt_s = fault_addr_r;
    if (pc_we && valid_s) begin
      if (mis_s) begin
        fault_nxt_s      = 1'b1;
        fault_addr_nxt_s = tgt_s;
      end else begin
        pc_nxt_s = tgt_s;
      end
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // State registers; reset has priority over every update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r         <= RESET_VEC;
      pc_old_r     <= RESET_VEC;
      fault_r      <= 1'b0;
      fault_addr_r <= '0;
    end else begin
      pc_r         <= pc_nxt_s;
      fault_r      <= fault_nxt_s;
      fault_addr_r <= fault_addr_nxt_s;
      // pc_old takes the pre-update pc even when pc_we fires on the same edge.
      if (ir_latch) begin
        pc_old_r <= pc_r;
      end else begin
        pc_old_r <= pc_old_r;
      end
    end
  end

  assign pc             = pc_r;
  assign pc_old         = pc_old_r;
  assign pc_plus        = pc_old_r + STEP_W;
  assign misalign_fault = fault_r;
  assign fault_addr     = fault_addr_r;

endmodule

// File: tb/tb_pc_unit.sv
`timescale 1ns/1ps
module tb_pc_unit;

  typedef logic [9:0][31:0] rec_t;

  logic        clk;
  logic        rst;
  logic        pc_we;
  logic [2:0]  pc_sel;
  logic        ir_latch;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [4:0]  trap_cause;
  logic        trap_irq;

  logic [31:0] pc_a, pc_old_a, pc_plus_a, fa_a;
  logic        f_a;
  logic [31:0] pc_b, pc_old_b, pc_plus_b, fa_b;
  logic        f_b;

  int checks;
  int failures;
  rec_t exp_q[$];
  rec_t obs_q[$];
  string fname [10];

  pc_unit #(.XLEN(32), .RESET_VEC(32'h0000_0100), .IALIGN(32), .STEP(4)) dut32 (
    .clk(clk), .rst(rst), .pc_we(pc_we), .pc_sel(pc_sel), .ir_latch(ir_latch),
    .imm(imm), .rs1(rs1), .mtvec(mtvec), .mepc(mepc), .trap_cause(trap_cause),
    .trap_irq(trap_irq), .pc(pc_a), .pc_old(pc_old_a), .pc_plus(pc_plus_a),
    .misalign_fault(f_a), .fault_addr(fa_a));

  pc_unit #(.XLEN(32), .RESET_VEC(32'h0000_0100), .IALIGN(16), .STEP(4)) dut16 (
    .clk(clk), .rst(rst), .pc_we(pc_we), .pc_sel(pc_sel), .ir_latch(ir_latch),
    .imm(imm), .rs1(rs1), .mtvec(mtvec), .mepc(mepc), .trap_cause(trap_cause),
    .trap_irq(trap_irq), .pc(pc_b), .pc_old(pc_old_b), .pc_plus(pc_plus_b),
    .misalign_fault(f_b), .fault_addr(fa_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected record: both instances share pc_old (latched only when their pcs agree);
  // the IALIGN=16 instance never faults, so its fault_addr stays 0.
  function automatic rec_t mk(input logic [31:0] p, input logic [31:0] old,
                              input logic f, input logic [31:0] fa,
                              input logic [31:0] p16);
    rec_t r;
    r[0] = p;
    r[1] = old;
    r[2] = old + 32'd4;
    r[3] = {31'd0, f};
    r[4] = fa;
    r[5] = p16;
    r[6] = old;
    r[7] = old + 32'd4;
    r[8] = 32'd0;
    r[9] = 32'd0;
    return r;
  endfunction

  task automatic cycle();
    rec_t o;
    @(posedge clk);
    #1;
    o[0] = pc_a;  o[1] = pc_old_a;  o[2] = pc_plus_a;  o[3] = {31'd0, f_a};  o[4] = fa_a;
    o[5] = pc_b;  o[6] = pc_old_b;  o[7] = pc_plus_b;  o[8] = {31'd0, f_b};  o[9] = fa_b;
    obs_q.push_back(o);
  endtask

  task automatic set_in(input logic r, input logic we, input logic lat, input logic [2:0] sel);
    rst = r; pc_we = we; ir_latch = lat; pc_sel = sel;
  endtask

  task automatic test_reset();
    rec_t e, o;
    set_in(1'b1, 1'b1, 1'b1, 3'd0);
    exp_q.push_back(mk(32'h100, 32'h100, 1'b0, 32'h0, 32'h100)); cycle();
    exp_q.push_back(mk(32'h100, 32'h100, 1'b0, 32'h0, 32'h100)); cycle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL reset missing observation got=none exp=entry");
      end else begin
        o = obs_q.pop_front();
        for (int k = 0; k < 10; k++) begin
          if (k != 0) checks++;
          if (o[k] !== e[k]) begin
            failures++; $display("FAIL reset.%s got=%h exp=%h", fname[k], o[k], e[k]);
          end
        end
      end
    end
  endtask

  task automatic test_seq_branch();
    rec_t e, o;
    set_in(1'b0, 1'b1, 1'b0, 3'd0);
    exp_q.push_back(mk(32'h104, 32'h100, 1'b0, 32'h0, 32'h104)); cycle();
    exp_q.push_back(mk(32'h108, 32'h100, 1'b0, 32'h0, 32'h108)); cycle();
    exp_q.push_back(mk(32'h10C, 32'h100, 1'b0, 32'h0, 32'h10C)); cycle();
    mepc = 32'h200; pc_sel = 3'd4;
    exp_q.push_back(mk(32'h200, 32'h100, 1'b0, 32'h0, 32'h200)); cycle();
    set_in(1'b0, 1'b1, 1'b1, 3'd0);
    exp_q.push_back(mk(32'h204, 32'h200, 1'b0, 32'h0, 32'h204)); cycle();
    set_in(1'b0, 1'b1, 1'b0, 3'd1); imm = 32'hFFFF_FFF8;
    exp_q.push_back(mk(32'h1F8, 32'h200, 1'b0, 32'h0, 32'h1F8)); cycle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL seq_branch missing observation got=none exp=entry");
      end else begin
        o = obs_q.pop_front();
        for (int k = 0; k < 10; k++) begin
          if (k != 0) checks++;
          if (o[k] !== e[k]) begin
            failures++; $display("FAIL seq_branch.%s got=%h exp=%h", fname[k], o[k], e[k]);
          end
        end
      end
    end
  endtask

  task automatic test_jalr();
    rec_t e, o;
    set_in(1'b0, 1'b1, 1'b0, 3'd2); rs1 = 32'h1001; imm = 32'h2;
    exp_q.push_back(mk(32'h1F8, 32'h200, 1'b1, 32'h1002, 32'h1002)); cycle();
    pc_we = 1'b0;
    exp_q.push_back(mk(32'h1F8, 32'h200, 1'b0, 32'h1002, 32'h1002)); cycle();
    pc_we = 1'b1; imm = 32'h0;
    exp_q.push_back(mk(32'h1000, 32'h200, 1'b0, 32'h1002, 32'h1000)); cycle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL jalr missing observation got=none exp=entry");
      end else begin
        o = obs_q.pop_front();
        for (int k = 0; k < 10; k++) begin
          if (k != 0) checks++;
          if (o[k] !== e[k]) begin
            failures++; $display("FAIL jalr.%s got=%h exp=%h", fname[k], o[k], e[k]);
          end
        end
      end
    end
  endtask

  task automatic test_trap();
    rec_t e, o;
    set_in(1'b0, 1'b1, 1'b0, 3'd3); mtvec = 32'h8001; trap_irq = 1'b1; trap_cause = 5'd7;
    exp_q.push_back(mk(32'h801C, 32'h200, 1'b0, 32'h1002, 32'h801C)); cycle();
    trap_irq = 1'b0;
    exp_q.push_back(mk(32'h8000, 32'h200, 1'b0, 32'h1002, 32'h8000)); cycle();
    mtvec = 32'h9003; trap_irq = 1'b1;
    exp_q.push_back(mk(32'h9000, 32'h200, 1'b0, 32'h1002, 32'h9000)); cycle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL trap missing observation got=none exp=entry");
      end else begin
        o = obs_q.pop_front();
        for (int k = 0; k < 10; k++) begin
          if (k != 0) checks++;
          if (o[k] !== e[k]) begin
            failures++; $display("FAIL trap.%s got=%h exp=%h", fname[k], o[k], e[k]);
          end
        end
      end
    end
  endtask

  task automatic test_mret_wrap();
    rec_t e, o;
    set_in(1'b0, 1'b1, 1'b0, 3'd4); mepc = 32'h3000;
    exp_q.push_back(mk(32'h3000, 32'h200, 1'b0, 32'h1002, 32'h3000)); cycle();
    mepc = 32'h3003;
    exp_q.push_back(mk(32'h3000, 32'h200, 1'b1, 32'h3002, 32'h3002)); cycle();
    mepc = 32'hFFFF_FFFC;
    exp_q.push_back(mk(32'hFFFF_FFFC, 32'h200, 1'b0, 32'h3002, 32'hFFFF_FFFC)); cycle();
    pc_sel = 3'd0;
    exp_q.push_back(mk(32'h0, 32'h200, 1'b0, 32'h3002, 32'h0)); cycle();
    pc_sel = 3'd6;
    exp_q.push_back(mk(32'h0, 32'h200, 1'b0, 32'h3002, 32'h0)); cycle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL mret_wrap missing observation got=none exp=entry");
      end else begin
        o = obs_q.pop_front();
        for (int k = 0; k < 10; k++) begin
          if (k != 0) checks++;
          if (o[k] !== e[k]) begin
            failures++; $display("FAIL mret_wrap.%s got=%h exp=%h", fname[k], o[k], e[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_fault();
    rec_t e, o;
    set_in(1'b0, 1'b1, 1'b0, 3'd1); imm = 32'h2;
    exp_q.push_back(mk(32'h0, 32'h200, 1'b1, 32'h202, 32'h202)); cycle();
    set_in(1'b1, 1'b1, 1'b1, 3'd1);
    exp_q.push_back(mk(32'h100, 32'h100, 1'b0, 32'h0, 32'h100)); cycle();
    set_in(1'b0, 1'b0, 1'b0, 3'd1);
    exp_q.push_back(mk(32'h100, 32'h100, 1'b0, 32'h0, 32'h100)); cycle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL reset_mid_fault missing observation got=none exp=entry");
      end else begin
        o = obs_q.pop_front();
        for (int k = 0; k < 10; k++) begin
          if (k != 0) checks++;
          if (o[k] !== e[k]) begin
            failures++; $display("FAIL reset_mid_fault.%s got=%h exp=%h", fname[k], o[k], e[k]);
          end
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; failures = 0;
    fname[0] = "pc32";     fname[1] = "pc_old32"; fname[2] = "pc_plus32";
    fname[3] = "fault32";  fname[4] = "faddr32";  fname[5] = "pc16";
    fname[6] = "pc_old16"; fname[7] = "pc_plus16"; fname[8] = "fault16";
    fname[9] = "faddr16";
    rst = 1'b1; pc_we = 1'b0; pc_sel = 3'd0; ir_latch = 1'b0;
    imm = 32'h0; rs1 = 32'h0; mtvec = 32'h0; mepc = 32'h0;
    trap_cause = 5'd0; trap_irq = 1'b0;
    @(negedge clk);
    test_reset();
    test_seq_branch();
    test_jalr();
    test_trap();
    test_mret_wrap();
    test_reset_mid_fault();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
